// File: rtl/hog_pkg.sv
// Shared constants and types for the HOG orientation-bin accumulator.
package hog_pkg;

   // Q4.16 tangents of 20, 40, 60 and 80 degrees
   localparam int unsigned T20 = 32'h0000_5D2D;
   localparam int unsigned T40 = 32'h0000_D6CF;
   localparam int unsigned T60 = 32'h0001_BB68;
   localparam int unsigned T80 = 32'h0005_ABD9;

   localparam int unsigned NBINS = 9;

   typedef logic [3:0] bin_idx_t;

endpackage

// File: rtl/hog_bin_sel.sv
// Combinational mapper from a signed Q4.16 gradient ratio to one of nine
// unsigned orientation bins (0..180 degrees in 20-degree steps).
module hog_bin_sel
   import hog_pkg::*;
#(
   parameter int unsigned R_W = 20
) (
   input  logic [R_W-1:0] ratio,
   output bin_idx_t       bin
);

   localparam logic [R_W:0] TH20 = (R_W+1)'(T20);
   localparam logic [R_W:0] TH40 = (R_W+1)'(T40);
   localparam logic [R_W:0] TH60 = (R_W+1)'(T60);
   localparam logic [R_W:0] TH80 = (R_W+1)'(T80);

   logic           neg;
   logic [R_W:0]   abs_ratio;
   logic [2:0]     zone;

   // One extra bit keeps |most negative| representable so it lands in bin 4
   always_comb begin
      neg       = ratio[R_W-1];
      abs_ratio = neg ? ((R_W+1)'(0) - {ratio[R_W-1], ratio}) : {1'b0, ratio};
      zone      = 3'd0;
      if (abs_ratio >= TH80)      zone = 3'd4;
      else if (abs_ratio >= TH60) zone = 3'd3;
      else if (abs_ratio >= TH40) zone = 3'd2;
      else if (abs_ratio >= TH20) zone = 3'd1;
      bin = neg ? bin_idx_t'(4'd8 - {1'b0, zone}) : bin_idx_t'({1'b0, zone});
   end

endmodule

// File: rtl/hog_bin_accum.sv
// Per-cell HOG histogram accumulator: two-stage pipeline (bin select, bin add)
// with a held output register. Define HOG_BIN_SAT_EN for saturating bin adds.
module hog_bin_accum
   import hog_pkg::*;
#(
   parameter int unsigned R_W      = 20,
   parameter int unsigned MAG_W    = 12,
   parameter int unsigned BIN_W    = 18,
   parameter int unsigned CELL_PIX = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [R_W-1:0]         ratio,
   input  logic [MAG_W-1:0]       mag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NBINS*BIN_W-1:0] hist
);

   localparam int unsigned CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;

   bin_idx_t         sel_bin;
   logic             accept;
   logic [CNT_W-1:0] pix_cnt;
   logic             cnt_last;
   logic             s1_valid;
   logic             s1_last;
   bin_idx_t         s1_bin;
   logic [MAG_W-1:0] s1_mag;
   logic [BIN_W-1:0] acc     [NBINS];
   logic [BIN_W-1:0] acc_upd [NBINS];

   function automatic logic [BIN_W-1:0] bin_add(input logic [BIN_W-1:0] a,
                                                input logic [MAG_W-1:0] m);
`ifdef HOG_BIN_SAT_EN
      logic [BIN_W:0] s;
      s = {1'b0, a} + (BIN_W+1)'(m);
      return s[BIN_W] ? '1 : s[BIN_W-1:0];
`else
      return a + BIN_W'(m);
`endif
   endfunction

   assign in_ready = !(out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign cnt_last = (pix_cnt == CNT_W'(CELL_PIX - 1));

   hog_bin_sel #(.R_W(R_W)) u_bin_sel (
      .ratio (ratio),
      .bin   (sel_bin)
   );

   // Stage-2 view of every bin with the current pixel folded in
   always_comb begin
      for (int unsigned k = 0; k < NBINS; k++) begin
         acc_upd[k] = acc[k];
         if (s1_bin == bin_idx_t'(k)) acc_upd[k] = bin_add(acc[k], s1_mag);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt   <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_bin    <= '0;
         s1_mag    <= '0;
         out_valid <= 1'b0;
         hist      <= '0;
         for (int unsigned k = 0; k < NBINS; k++) acc[k] <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_bin  <= sel_bin;
            s1_mag  <= mag;
            s1_last <= cnt_last;
            pix_cnt <= cnt_last ? '0 : pix_cnt + CNT_W'(1);
         end
         // Last pixel of a cell: publish final sums and restart from zero
         if (s1_valid && s1_last) begin
            for (int unsigned k = 0; k < NBINS; k++) begin
               hist[k*BIN_W +: BIN_W] <= acc_upd[k];
               acc[k]                 <= '0;
            end
            out_valid <= 1'b1;
         end else begin
            if (s1_valid) begin
               for (int unsigned k = 0; k < NBINS; k++) acc[k] <= acc_upd[k];
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hog_bin_accum.sv
// Self-checking bench for hog_bin_accum: cell-level model plus literal checks.
module tb_hog_bin_accum;

   localparam int BW  = 18;
   localparam int HW  = 9 * BW;
   localparam int BW2 = 16;
   localparam int HW2 = 9 * BW2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [19:0]    ratio = '0;
   logic [11:0]    mag = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [HW-1:0]  hist;

   logic           in_valid2 = 1'b0;
   logic           in_ready2;
   logic [19:0]    ratio2 = '0;
   logic [11:0]    mag2 = '0;
   logic           out_valid2;
   logic           out_ready2 = 1'b0;
   logic [HW2-1:0] hist2;

   int n_checks = 0;
   int n_fail   = 0;

   longint        model_sum [9];
   int            model_cnt;
   logic [HW-1:0] exp_q [$];
   bit            prev_hold = 1'b0;
   logic [HW-1:0] prev_hist;

   always #5 clk = ~clk;

   hog_bin_accum u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ratio(ratio), .mag(mag), .out_valid(out_valid), .out_ready(out_ready),
      .hist(hist)
   );

   hog_bin_accum #(.BIN_W(BW2)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .ratio(ratio2), .mag(mag2), .out_valid(out_valid2), .out_ready(out_ready2),
      .hist(hist2)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Orientation bin straight from the angle-threshold rules
   function automatic int bin_of(input logic [19:0] r);
      int v;
      int a;
      v = $signed(r);
      a = (v < 0) ? -v : v;
      if (v >= 0) begin
         if (a < 'h05D2D) return 0;
         if (a < 'h0D6CF) return 1;
         if (a < 'h1BB68) return 2;
         if (a < 'h5ABD9) return 3;
         return 4;
      end
      if (a >= 'h5ABD9) return 4;
      if (a >= 'h1BB68) return 5;
      if (a >= 'h0D6CF) return 6;
      if (a >= 'h05D2D) return 7;
      return 8;
   endfunction

   function automatic logic [HW-1:0] model_hist();
      logic [HW-1:0] v;
      longint s;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         s = model_sum[k];
`ifdef HOG_BIN_SAT_EN
         if (s > (64'd1 << BW) - 1) s = (64'd1 << BW) - 1;
`else
         s = s % (64'd1 << BW);
`endif
         v[k*BW +: BW] = BW'(s);
      end
      return v;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 9; k++) model_sum[k] = 0;
      model_cnt = 0;
   endfunction

   // Cycle monitor: handshake rule, hold stability, and model scoreboard
   always @(negedge clk) begin
      if (rst) begin
         model_clear();
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_hist", hist, prev_hist);
         end
         if (in_valid && in_ready) begin
            model_sum[bin_of(ratio)] += mag;
            model_cnt++;
            if (model_cnt == 64) begin
               exp_q.push_back(model_hist());
               model_clear();
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check("hist_model", hist, exp_q.pop_front());
         end
         prev_hold = out_valid && !out_ready;
         prev_hist = hist;
      end
   end

   task automatic push(input logic [19:0] r, input logic [11:0] m);
      bit got;
      int waited;
      got = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      ratio = r;
      mag = m;
      while (!got) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         waited++;
         if (!got && waited > 200) begin
            check("push_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check(name, 0, 1);
   endtask

   initial begin
      logic [HW-1:0]  e;
      logic [HW2-1:0] e2;
      int acc_n;
      int n;

      // Pin the bench's own bin rule against hand-derived values
      check("model_zero", bin_of(20'h00000), 0);
      check("model_minneg", bin_of(20'h80000), 4);
      check("model_t20m", bin_of(20'hFA2D3), 7);
      check("model_t60", bin_of(20'h1BB68), 3);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_hist", hist, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // 64 zero-ratio unit pixels, output held, latency N+2
      for (int i = 0; i < 64; i++) push(20'h00000, 12'd1);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_n1", out_valid, 0);
      @(negedge clk);
      check("lat_n2", out_valid, 1);
      e = '0;
      e[0 +: BW] = BW'(64);
      check("cell_zero_hist", hist, e);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("drop_after_take", out_valid, 0);

      // Threshold boundaries
      out_ready = 1'b1;
      push(20'h05D2C, 12'd1);
      push(20'h05D2D, 12'd1);
      push(20'h5ABD9, 12'd1);
      push(20'hA5427, 12'd1);
      push(20'hFA2D3, 12'd1);
      push(20'hFA2D4, 12'd1);
      for (int i = 0; i < 58; i++) push(20'h0D6CF, 12'd0);
      in_valid = 1'b0;
      wait_out("bound_timeout");
      e = '0;
      e[0*BW +: BW] = BW'(1);
      e[1*BW +: BW] = BW'(1);
      e[4*BW +: BW] = BW'(2);
      e[7*BW +: BW] = BW'(1);
      e[8*BW +: BW] = BW'(1);
      check("boundary_hist", hist, e);
      @(posedge clk);
      #1;

      // Mixed ratios and magnitudes
      for (int i = 0; i < 64; i++) push(20'(i * 32'h2B3C5 + 32'h1234), 12'(i * 61 + 5));
      in_valid = 1'b0;
      wait_out("pattern_timeout");
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;

      // Two back-to-back cells against a stalled consumer
      fork
         begin
            for (int i = 0; i < 128; i++) push(20'(32'hF0000 + i * 32'h1F3D), 12'(4095 - i * 29));
            in_valid = 1'b0;
         end
         begin
            wait_out("stall_timeout");
            check("stall_in_ready", in_ready, 0);
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("two_cells_drained", exp_q.size(), 0);

      // Reset mid-cell discards the partial sums
      for (int i = 0; i < 30; i++) push(20'h10000, 12'd7);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_hist", hist, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) push(20'hB0000, 12'd2);
      in_valid = 1'b0;
      wait_out("midrst_timeout");
      e = '0;
      e[5*BW +: BW] = BW'(128);
      check("midrst_cell_hist", hist, e);
      @(posedge clk);
      #1;

      // 16-bit bins with full-scale magnitude (0x20000 falls in bin 3)
      out_ready2 = 1'b1;
      in_valid2  = 1'b1;
      ratio2     = 20'h20000;
      mag2       = 12'hFFF;
      acc_n = 0;
      n = 0;
      while (acc_n < 64 && n < 300) begin
         @(negedge clk);
         if (in_ready2) acc_n++;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid2 = 1'b0;
      check("w16_accepts", acc_n, 64);
      n = 0;
      @(negedge clk);
      while (!out_valid2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("w16_out_valid", out_valid2, 1);
      e2 = '0;
`ifdef HOG_BIN_SAT_EN
      e2[3*BW2 +: BW2] = 16'd65535;
`else
      e2[3*BW2 +: BW2] = 16'd65472;
`endif
      check("w16_hist", hist2, e2);

      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
